// File: rtl/mem_write_monitor.sv
// End-of-test monitor for the core's data-memory write bus: tohost pass/fail,
// cycle timeout, optional strict store checking and a console log FIFO.
module mem_write_monitor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TOHOST_ADDR = 32,
  parameter int unsigned TIMEOUT     = 100000,
  parameter int unsigned STRICT      = 0,
  parameter int unsigned LOG_BASE    = 96,
  parameter int unsigned LOG_SIZE    = 32,
  parameter int unsigned LOG_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] DataAdr,
  input  logic [XLEN-1:0] WriteData,
  output logic            done,
  output logic            pass,
  output logic [1:0]      status,
  output logic [XLEN-1:0] fail_code,
  output logic [XLEN-1:0] fail_adr,
  output logic [31:0]     cycles,
  output logic [15:0]     stores,
  output logic            log_valid,
  output logic [XLEN-1:0] log_adr,
  output logic [XLEN-1:0] log_data,
  input  logic            log_ready,
  output logic            log_overflow
);

  localparam int unsigned     AW       = $clog2(LOG_DEPTH);
  localparam logic [XLEN-1:0] TOHOST_A = XLEN'(TOHOST_ADDR);
  localparam logic [XLEN-1:0] LBASE_A  = XLEN'(LOG_BASE);
  localparam logic [XLEN-1:0] LSIZE_A  = XLEN'(LOG_SIZE);
  localparam logic [31:0]     TO_M1    = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_PASS    = 2'b01,
    S_FAIL    = 2'b10,
    S_TIMEOUT = 2'b11
  } state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] fail_code_nx, fail_adr_nx;

  logic [XLEN-1:0] mem_adr  [LOG_DEPTH];
  logic [XLEN-1:0] mem_data [LOG_DEPTH];
  logic [AW:0]     wptr, rptr;

  logic accept, hit_tohost, hit_log;
  logic empty, full, pop, push, drop;

  always_comb begin
    accept     = MemWrite && (state == S_RUN);
    hit_tohost = (DataAdr == TOHOST_A);
    // Offset compare avoids overflow of LOG_BASE+LOG_SIZE near the top of the address space.
    hit_log    = !hit_tohost && (DataAdr >= LBASE_A) && ((DataAdr - LBASE_A) < LSIZE_A);
    empty      = (wptr == rptr);
    full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    pop        = !empty && log_ready;
    push       = accept && hit_log && (!full || pop);
    drop       = accept && hit_log && full && !pop;
  end

  always_comb begin
    state_nx     = state;
    fail_code_nx = fail_code;
    fail_adr_nx  = fail_adr;
    if (state == S_RUN) begin
      if (accept && hit_tohost) begin
        fail_adr_nx = DataAdr;
        if (WriteData == XLEN'(1)) begin
          state_nx = S_PASS;
        end else begin
          state_nx     = S_FAIL;
          fail_code_nx = WriteData;
        end
      end else if (accept && !hit_log && (STRICT != 0)) begin
        state_nx    = S_FAIL;
        fail_adr_nx = DataAdr;
      end else if ((TIMEOUT != 0) && (cycles == TO_M1)) begin
        state_nx = S_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_RUN;
      fail_code    <= '0;
      fail_adr     <= '0;
      cycles       <= '0;
      stores       <= '0;
      log_overflow <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      for (int unsigned i = 0; i < LOG_DEPTH; i++) begin
        mem_adr[i]  <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      state     <= state_nx;
      fail_code <= fail_code_nx;
      fail_adr  <= fail_adr_nx;
      if (state == S_RUN)
        cycles <= cycles + 32'd1;
      if (accept && (stores != 16'hFFFF))
        stores <= stores + 16'd1;
      if (drop)
        log_overflow <= 1'b1;
      // When full, the written slot is the one being popped this same edge.
      if (push) begin
        mem_adr[wptr[AW-1:0]]  <= DataAdr;
        mem_data[wptr[AW-1:0]] <= WriteData;
        wptr                   <= wptr + 1'b1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
    end
  end

  always_comb begin
    status    = state;
    done      = (state != S_RUN);
    pass      = (state == S_PASS);
    log_valid = !empty;
    log_adr   = empty ? '0 : mem_adr[rptr[AW-1:0]];
    log_data  = empty ? '0 : mem_data[rptr[AW-1:0]];
  end

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor: lax instance (a_*) and strict instance (b_*)
// share stimulus; TIMEOUT=20 and LOG_DEPTH=4 on both.
module tb_mem_write_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mw = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wd = '0;
  logic        lr = 1'b0;

  logic        a_done, a_pass, a_lv, a_ovf;
  logic [1:0]  a_status;
  logic [31:0] a_fcode, a_fadr, a_cycles, a_ladr, a_ldata;
  logic [15:0] a_stores;
  logic        b_done, b_pass, b_lv, b_ovf;
  logic [1:0]  b_status;
  logic [31:0] b_fcode, b_fadr, b_cycles, b_ladr, b_ldata;
  logic [15:0] b_stores;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_write_monitor #(.TIMEOUT(20), .LOG_DEPTH(4), .STRICT(0)) dut_a (
    .clk(clk), .reset(rst_n), .MemWrite(mw), .DataAdr(adr), .WriteData(wd),
    .done(a_done), .pass(a_pass), .status(a_status), .fail_code(a_fcode),
    .fail_adr(a_fadr), .cycles(a_cycles), .stores(a_stores), .log_valid(a_lv),
    .log_adr(a_ladr), .log_data(a_ldata), .log_ready(lr), .log_overflow(a_ovf)
  );

  mem_write_monitor #(.TIMEOUT(20), .LOG_DEPTH(4), .STRICT(1)) dut_b (
    .clk(clk), .reset(rst_n), .MemWrite(mw), .DataAdr(adr), .WriteData(wd),
    .done(b_done), .pass(b_pass), .status(b_status), .fail_code(b_fcode),
    .fail_adr(b_fadr), .cycles(b_cycles), .stores(b_stores), .log_valid(b_lv),
    .log_adr(b_ladr), .log_data(b_ldata), .log_ready(lr), .log_overflow(b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mw    = 1'b0;
    lr    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mw  = 1'b1;
    adr = a;
    wd  = d;
    step();
    mw  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_status"}, {30'd0, a_status}, 32'd0);
    check({tag, "_done"},   {31'd0, a_done},   32'd0);
    check({tag, "_pass"},   {31'd0, a_pass},   32'd0);
    check({tag, "_fcode"},  a_fcode,           32'd0);
    check({tag, "_fadr"},   a_fadr,            32'd0);
    check({tag, "_cycles"}, a_cycles,          32'd0);
    check({tag, "_stores"}, {16'd0, a_stores}, 32'd0);
    check({tag, "_lvalid"}, {31'd0, a_lv},     32'd0);
    check({tag, "_ladr"},   a_ladr,            32'd0);
    check({tag, "_ldata"},  a_ldata,           32'd0);
    check({tag, "_ovf"},    {31'd0, a_ovf},    32'd0);
  endtask

  initial begin
    #3;
    check_reset_state("rst0");

    // tohost pass at RUN cycle 10, then a later store is ignored
    do_reset();
    repeat (10) step();
    store(32'd32, 32'd1);
    check("pass_status", {30'd0, a_status}, 32'd1);
    check("pass_pass",   {31'd0, a_pass},   32'd1);
    check("pass_done",   {31'd0, a_done},   32'd1);
    check("pass_fcode",  a_fcode,           32'd0);
    check("pass_fadr",   a_fadr,            32'd32);
    check("pass_cycles", a_cycles,          32'd11);
    check("pass_stores", {16'd0, a_stores}, 32'd1);
    store(32'd32, 32'd0);
    check("late_status", {30'd0, a_status}, 32'd1);
    check("late_cycles", a_cycles,          32'd11);
    check("late_stores", {16'd0, a_stores}, 32'd1);

    // tohost fail with code 7, and with code 0
    do_reset();
    store(32'd32, 32'd7);
    check("fail7_status", {30'd0, a_status}, 32'd2);
    check("fail7_fcode",  a_fcode,           32'd7);
    check("fail7_fadr",   a_fadr,            32'd32);
    check("fail7_pass",   {31'd0, a_pass},   32'd0);
    do_reset();
    store(32'd32, 32'd0);
    check("fail0_status", {30'd0, a_status}, 32'd2);
    check("fail0_fcode",  a_fcode,           32'd0);

    // timeout with no stores
    do_reset();
    repeat (19) step();
    check("to19_status", {30'd0, a_status}, 32'd0);
    check("to19_cycles", a_cycles,          32'd19);
    step();
    check("to_status", {30'd0, a_status}, 32'd3);
    check("to_cycles", a_cycles,          32'd20);
    check("to_done",   {31'd0, a_done},   32'd1);
    step();
    check("to_frozen", a_cycles, 32'd20);

    // tohost store on the 20th edge beats the timeout
    do_reset();
    repeat (19) step();
    store(32'd32, 32'd1);
    check("race_status", {30'd0, a_status}, 32'd1);
    check("race_cycles", a_cycles,          32'd20);

    // store outside tohost/log window: strict fails, lax only counts
    do_reset();
    store(32'd200, 32'd5);
    check("strict_status", {30'd0, b_status}, 32'd2);
    check("strict_fadr",   b_fadr,            32'd200);
    check("strict_fcode",  b_fcode,           32'd0);
    check("lax_status",    {30'd0, a_status}, 32'd0);
    check("lax_stores",    {16'd0, a_stores}, 32'd1);

    // log FIFO overflow, in-order drain, reset mid-drain
    do_reset();
    for (int i = 0; i < 4; i++) store(32'd96 + 32'(4 * i), 32'hD0 + 32'(i));
    check("fifo4_ovf",  {31'd0, a_ovf}, 32'd0);
    check("fifo4_lv",   {31'd0, a_lv},  32'd1);
    store(32'd112, 32'hD4);
    check("fifo5_ovf",    {31'd0, a_ovf},    32'd1);
    check("fifo5_stores", {16'd0, a_stores}, 32'd5);
    check("strict_log_ok", {30'd0, b_status}, 32'd0);
    lr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_lv", i),    {31'd0, a_lv}, 32'd1);
      check($sformatf("drain%0d_adr", i),   a_ladr,        32'd96 + 32'(4 * i));
      check($sformatf("drain%0d_data", i),  a_ldata,       32'hD0 + 32'(i));
      step();
    end
    check("drained_lv", {31'd0, a_lv}, 32'd0);

    do_reset();
    for (int i = 0; i < 4; i++) store(32'd96 + 32'(4 * i), 32'hE0 + 32'(i));
    lr = 1'b1;
    store(32'd112, 32'hE4);
    check("pp_ovf",  {31'd0, a_ovf}, 32'd0);
    check("pp_lv",   {31'd0, a_lv},  32'd1);
    check("pp_adr",  a_ladr,         32'd100);
    check("pp_data", a_ldata,        32'hE1);
    for (int i = 1; i < 3; i++) begin
      check($sformatf("pp%0d_data", i), a_ldata, 32'hE0 + 32'(i));
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    do_reset();
    step();
    check("post_rst_lv", {31'd0, a_lv}, 32'd0);
    check("post_rst_cycles", a_cycles, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_write_monitor.md
# mem_write_monitor

Synthesizable end-of-test monitor for the RV32I core's data-memory write bus. It replaces the fixed "store to address 32" check in the simulation bench with a parametrised, cycle-accurate checker. Features: configurable tohost address, cycle timeout, strict/lax handling of unexpected stores, and a small log FIFO that captures stores to a console window for draining. It sits beside `top`, snooping `MemWrite`/`DataAdr`/`WriteData`, and is usable in simulation and on FPGA.

## Interface
- `XLEN`, 32, data/address width
- `TOHOST_ADDR`, 32, address whose store ends the test
- `TIMEOUT`, 100000, cycle limit in RUN; 0 disables the timeout
- `STRICT`, 0, 1 = any store outside tohost/log window is a failure
- `LOG_BASE`, 96, first byte address of log window
- `LOG_SIZE`, 32, log window size in bytes; window is [LOG_BASE, LOG_BASE+LOG_SIZE)
- `LOG_DEPTH`, 8, log FIFO entries, power of 2, ≥2
- `clk`  input  1  clock, rising edge
- `reset`  input  1  asynchronous, active-low (0 = reset)
- `MemWrite`  input  1  store strobe from core
- `DataAdr`  input  XLEN  store address
- `WriteData`  input  XLEN  store data
- `done`  output  1  test finished (status ≠ RUN)
- `pass`  output  1  status == PASS
- `status`  output  2  00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT
- `fail_code`  output  XLEN  WriteData of failing tohost store, else 0
- `fail_adr`  output  XLEN  address of the terminating or offending store
- `cycles`  output  32  cycles spent in RUN
- `stores`  output  16  accepted stores, saturating at 0xFFFF
- `log_valid`  output  1  log FIFO head valid
- `log_adr`  output  XLEN  head entry address
- `log_data`  output  XLEN  head entry data
- `log_ready`  input  1  consumer pops head when high with log_valid
- `log_overflow`  output  1  sticky: a log store was dropped

## Operation
- FSM states RUN, PASS, FAIL, TIMEOUT. Only RUN has exits; the other three are sticky until reset.
- A store is accepted on a rising edge with `MemWrite`=1 and state RUN. Stores in other states are ignored: no counters or FIFO change.
- Classification priority: tohost, then log window, then other.
- tohost with WriteData==1: go to PASS, set fail_adr=DataAdr, leave fail_code=0.
- tohost with any other value: go to FAIL, set fail_code=WriteData and fail_adr=DataAdr. A value of 0 is a failure.
- Log window: push {DataAdr, WriteData} into the FIFO.
- Other with STRICT=1: go to FAIL, fail_code=0, fail_adr=DataAdr. With STRICT=0: count only.
- Every accepted store increments `stores`. The counter saturates at 0xFFFF.
- `cycles` increments on every edge in RUN, including the terminating edge, and freezes afterwards.
- Timeout: go to TIMEOUT on the edge where `cycles`==TIMEOUT-1 and no terminating store is accepted that edge. A terminating store on that same edge wins.
- FIFO push when full without a simultaneous pop: the entry is dropped and log_overflow is set.
- FIFO push when full with a simultaneous pop: the push is accepted and occupancy is unchanged.
- Pop occurs when log_valid && log_ready. Popping is allowed in every state, so draining continues after done.
- Pointers are log2(LOG_DEPTH)+1 bits wide and wrap modulo 2·LOG_DEPTH. Full/empty is decided by comparing the MSBs.

## Timing
- All outputs are registered. No combinational path runs from inputs to outputs.
- Reset values: status=RUN, done=0, pass=0, fail_code=0, fail_adr=0, cycles=0, stores=0, log_valid=0, log_adr=0, log_data=0, log_overflow=0, FIFO empty.
- Reset is asserted asynchronously and released synchronously to clk in the surrounding design. Asserting reset mid-test clears every register immediately, including FIFO contents.
- A store sampled on edge N is reflected in status, counters and log_valid after edge N. Latency is 1 cycle.
- No fall-through: a push into an empty FIFO makes log_valid go high the cycle after the push edge.
- The head holds stable while log_valid=1 and log_ready=0.

## Test plan
- tohost pass: reset 2 cycles, then store (32, 1) at RUN cycle 10 -> status=01, pass=1, fail_code=0, fail_adr=32, cycles=11, stores=1. A later store (32, 0) changes nothing.
- tohost fail: store (32, 7) -> status=10, fail_code=7, fail_adr=32. A store (32, 0) alone -> status=10, fail_code=0.
- Timeout race: TIMEOUT=20, no stores -> status=11 with cycles=20. Rerun with store (32, 1) on the 20th edge -> status=01.
- STRICT=1: store (200, 5) -> status=10, fail_adr=200, fail_code=0. With STRICT=0 the same store -> status=00, stores=1.
- Log FIFO: LOG_DEPTH=4, log_ready=0, push 5 stores to 96..112 -> 4 entries kept, log_overflow=1. Then raise log_ready -> drains (96,d0) through (108,d3) in order, one per cycle.
- FIFO full with simultaneous push and pop keeps 4 entries and leaves log_overflow unchanged. Asserting reset mid-drain -> log_valid=0 on that edge and all outputs return to their reset values.
